// File: rtl/video_pkg.sv
// Shared definitions for the raster timing generator: phase encoding, default
// 800x600@60 timing and pixel width.
package video_pkg;

   localparam int unsigned PixelW = 24;

   localparam int unsigned DefHActive = 800;
   localparam int unsigned DefHFp     = 40;
   localparam int unsigned DefHSync   = 128;
   localparam int unsigned DefHBp     = 88;
   localparam int unsigned DefVActive = 600;
   localparam int unsigned DefVFp     = 1;
   localparam int unsigned DefVSync   = 4;
   localparam int unsigned DefVBp     = 23;

   typedef enum logic [1:0] {
      PhaseActive = 2'd0,
      PhaseFront  = 2'd1,
      PhaseSync   = 2'd2,
      PhaseBack   = 2'd3
   } phase_e;

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Both step only when Advance is high; wrap flags the cycle the count returns to 0.
module video_axis_counter
   import video_pkg::*;
#(
   parameter int unsigned ACTIVE = DefHActive,
   parameter int unsigned FP     = DefHFp,
   parameter int unsigned SYNC   = DefHSync,
   parameter int unsigned BP     = DefHBp,
   localparam int unsigned Total = ACTIVE + FP + SYNC + BP,
   localparam int unsigned CntW  = $clog2(Total)
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic            Advance,
   output logic [CntW-1:0] count,
   output phase_e          phase,
   output logic            wrap
);

   localparam logic [CntW-1:0] EndActive = CntW'(ACTIVE - 1);
   localparam logic [CntW-1:0] EndFront  = CntW'(ACTIVE + FP - 1);
   localparam logic [CntW-1:0] EndSync   = CntW'(ACTIVE + FP + SYNC - 1);
   localparam logic [CntW-1:0] EndTotal  = CntW'(Total - 1);

   logic [CntW-1:0] count_q, count_d;
   phase_e          phase_q, phase_d;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         count_q <= '0;
         phase_q <= PhaseActive;
      end else begin
         count_q <= count_d;
         phase_q <= phase_d;
      end
   end

   always_comb begin
      count_d = count_q;
      phase_d = phase_q;
      wrap    = 1'b0;
      if (Advance) begin
         if (count_q == EndTotal) begin
            count_d = '0;
            wrap    = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
         // Phase moves on the last count of its region, so it tracks count_d.
         unique case (phase_q)
            PhaseActive: if (count_q == EndActive) phase_d = PhaseFront;
            PhaseFront:  if (count_q == EndFront)  phase_d = PhaseSync;
            PhaseSync:   if (count_q == EndSync)   phase_d = PhaseBack;
            PhaseBack:   if (count_q == EndTotal)  phase_d = PhaseActive;
            default:     phase_d = PhaseActive;
         endcase
      end
   end

   assign count = count_q;
   assign phase = phase_q;

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing generator: pulls one pixel per active clock and registers pixel,
// syncs, DataEnable and FrameStart together. VIDEO_TIMING_BORDER_EN forces a white border.
module video_timing_ctrl
   import video_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = DefHActive,
   parameter int unsigned H_FP      = DefHFp,
   parameter int unsigned H_SYNC    = DefHSync,
   parameter int unsigned H_BP      = DefHBp,
   parameter int unsigned V_ACTIVE  = DefVActive,
   parameter int unsigned V_FP      = DefVFp,
   parameter int unsigned V_SYNC    = DefVSync,
   parameter int unsigned V_BP      = DefVBp,
   parameter logic        HSYNC_POL = 1'b1,
   parameter logic        VSYNC_POL = 1'b1
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [PixelW-1:0] Video,
   output logic              VideoReady,
   output logic [7:0]        Red,
   output logic [7:0]        Green,
   output logic [7:0]        Blue,
   output logic              HSync,
   output logic              VSync,
   output logic              DataEnable,
   output logic              FrameStart
);

   localparam int unsigned HCntW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam int unsigned VCntW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

   logic [HCntW-1:0]  h_count;
   logic [VCntW-1:0]  v_count;
   phase_e            h_phase, v_phase;
   logic              h_wrap;
   logic              v_wrap_unused;
   logic [PixelW-1:0] pixel_d;

   logic [PixelW-1:0] pix_q;
   logic              de_q, hs_q, vs_q, fs_q;

   video_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .Clock   (Clock),
      .Reset   (Reset),
      .Advance (1'b1),
      .count   (h_count),
      .phase   (h_phase),
      .wrap    (h_wrap)
   );

   video_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .Clock   (Clock),
      .Reset   (Reset),
      .Advance (h_wrap),
      .count   (v_count),
      .phase   (v_phase),
      .wrap    (v_wrap_unused)
   );

   assign VideoReady = (h_phase == PhaseActive) && (v_phase == PhaseActive);

`ifdef VIDEO_TIMING_BORDER_EN
   // Border pixels are still consumed upstream so the source stays aligned.
   logic border;
   always_comb begin
      border  = (h_count == '0) || (h_count == HCntW'(H_ACTIVE - 1)) ||
                (v_count == '0) || (v_count == VCntW'(V_ACTIVE - 1));
      pixel_d = border ? {PixelW{1'b1}} : Video;
   end
`else
   assign pixel_d = Video;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) begin
         pix_q <= '0;
         de_q  <= 1'b0;
         hs_q  <= ~HSYNC_POL;
         vs_q  <= ~VSYNC_POL;
         fs_q  <= 1'b0;
      end else begin
         pix_q <= VideoReady ? pixel_d : '0;
         de_q  <= VideoReady;
         hs_q  <= (h_phase == PhaseSync) ? HSYNC_POL : ~HSYNC_POL;
         vs_q  <= (v_phase == PhaseSync) ? VSYNC_POL : ~VSYNC_POL;
         fs_q  <= (h_count == '0) && (v_count == '0);
      end
   end

   assign Red        = pix_q[23:16];
   assign Green      = pix_q[15:8];
   assign Blue       = pix_q[7:0];
   assign HSync      = hs_q;
   assign VSync      = vs_q;
   assign DataEnable = de_q;
   assign FrameStart = fs_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Scoreboard bench for video_timing_ctrl on a reduced raster, with an active-high
// and an active-low sync instance sharing one stimulus stream.
module tb_video_timing_ctrl;

   localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
   localparam int VA = 4, VFP = 1, VS = 2, VBP = 2;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int NCYC = 1000;

   bit          Clock;
   logic        Reset;
   logic [23:0] Video;

   logic       rdy0, hs0, vs0, de0, fs0;
   logic [7:0] r0, g0, b0;
   logic       rdy1, hs1, vs1, de1, fs1;
   logic [7:0] r1, g1, b1;

   typedef struct {
      bit        rst;
      bit [23:0] pix;
      bit        de;
      bit        hs_in;
      bit        vs_in;
      bit        fs;
      bit        nready;
   } item_t;

   item_t q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   always #5 Clock = ~Clock;

   video_timing_ctrl #(
      .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
      .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
      .HSYNC_POL (1'b1), .VSYNC_POL (1'b1)
   ) dut_pos (
      .Clock (Clock), .Reset (Reset), .Video (Video), .VideoReady (rdy0),
      .Red (r0), .Green (g0), .Blue (b0), .HSync (hs0), .VSync (vs0),
      .DataEnable (de0), .FrameStart (fs0)
   );

   video_timing_ctrl #(
      .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
      .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
      .HSYNC_POL (1'b0), .VSYNC_POL (1'b0)
   ) dut_neg (
      .Clock (Clock), .Reset (Reset), .Video (Video), .VideoReady (rdy1),
      .Red (r1), .Green (g1), .Blue (b1), .HSync (hs1), .VSync (vs1),
      .DataEnable (de1), .FrameStart (fs1)
   );

   function automatic bit ready_at(input int t);
      int x, y;
      x = t % HT;
      y = (t / HT) % VT;
      return (x < HA) && (y < VA);
   endfunction

   task automatic chk(input string name, input int cyc, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
   endtask

   // Stimulus and reference model: position is just elapsed cycles since reset.
   initial begin
      int t;
      int rcyc;
      t    = 0;
      rcyc = int'($urandom_range(400, 300));
      for (int i = 0; i < NCYC; i++) begin
         item_t it;
         bit    rst;
         int    x, y;
         bit    rdy;
         bit [23:0] px;
         rst   = (i < 3) || (i == 170) || (i == 171) || (i == rcyc);
         Reset = rst;
         Video = 24'($urandom);
         it.rst = rst;
         if (rst) begin
            it.pix = '0; it.de = 0; it.hs_in = 0; it.vs_in = 0; it.fs = 0;
            t = 0;
         end else begin
            x   = t % HT;
            y   = (t / HT) % VT;
            rdy = (x < HA) && (y < VA);
            px  = Video;
`ifdef VIDEO_TIMING_BORDER_EN
            if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) px = 24'hFFFFFF;
`endif
            it.pix   = rdy ? px : 24'h0;
            it.de    = rdy;
            it.hs_in = (x >= HA + HFP) && (x < HA + HFP + HS);
            it.vs_in = (y >= VA + VFP) && (y < VA + VFP + VS);
            it.fs    = (x == 0) && (y == 0);
            t++;
         end
         it.nready = ready_at(t);
         q.push_back(it);
         @(negedge Clock);
      end
   end

   // Monitor: one registered output set per clock, plus whole-frame totals.
   initial begin
      int prev_fs, de_cnt, rdy_cnt;
      item_t it;
      prev_fs = -1;
      de_cnt  = 0;
      rdy_cnt = 0;
      for (int i = 0; i < NCYC; i++) begin
         @(posedge Clock);
         #1;
         if (q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty cycle %0d: got 0 items expected 1", i);
         end else begin
            it = q.pop_front();
            chk("pix_pos",   i, 32'({r0, g0, b0}), 32'(it.pix));
            chk("de_pos",    i, 32'(de0),  32'(it.de));
            chk("hsync_pos", i, 32'(hs0),  32'(it.hs_in));
            chk("vsync_pos", i, 32'(vs0),  32'(it.vs_in));
            chk("fs_pos",    i, 32'(fs0),  32'(it.fs));
            chk("ready_pos", i, 32'(rdy0), 32'(it.nready));
            chk("pix_neg",   i, 32'({r1, g1, b1}), 32'(it.pix));
            chk("de_neg",    i, 32'(de1),  32'(it.de));
            chk("hsync_neg", i, 32'(hs1),  32'(!it.hs_in));
            chk("vsync_neg", i, 32'(vs1),  32'(!it.vs_in));
            chk("fs_neg",    i, 32'(fs1),  32'(it.fs));
            chk("ready_neg", i, 32'(rdy1), 32'(it.nready));
            if (it.rst) begin
               prev_fs = -1;
            end else begin
               if (fs0 === 1'b1) begin
                  if (prev_fs >= 0) begin
                     chk("frame_period",      i, 32'(i - prev_fs), 32'(HT * VT));
                     chk("frame_de_count",    i, 32'(de_cnt),      32'(HA * VA));
                     chk("frame_ready_count", i, 32'(rdy_cnt),     32'(HA * VA));
                  end
                  prev_fs = i;
                  de_cnt  = 0;
                  rdy_cnt = 0;
               end
               de_cnt  += (de0 === 1'b1) ? 1 : 0;
               rdy_cnt += (rdy0 === 1'b1) ? 1 : 0;
            end
         end
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/video_timing_ctrl.md
Name: video_timing_ctrl

Overview:
- Raster timing generator directly downstream of the pattern generator.
- Drives VideoReady to pull one 24-bit pixel per active-region clock and registers that pixel onto the display interface.
- Generates HSync, VSync and DataEnable in the same register stage as the pixel, so all outputs are aligned.
- Defaults give 800x600 @ 60 Hz with a 40 MHz pixel clock on Clock.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch in clocks
- H_SYNC, 128, horizontal sync width in clocks
- H_BP, 88, horizontal back porch in clocks
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch in lines
- V_SYNC, 4, vertical sync width in lines
- V_BP, 23, vertical back porch in lines
- HSYNC_POL, 1, HSync level while in sync (1 = active-high)
- VSYNC_POL, 1, VSync level while in sync

Ports:
- Clock  in  1  pixel clock
- Reset  in  1  synchronous, active-high
- Video  in  24  pixel from upstream, {R[23:16], G[15:8], B[7:0]}; valid whenever VideoReady is high
- VideoReady  out  1  combinational; high while the current counter position is active; upstream advances on this edge
- Red / Green / Blue  out  8 each  registered pixel components
- HSync  out  1  registered horizontal sync
- VSync  out  1  registered vertical sync
- DataEnable  out  1  registered active-region flag
- FrameStart  out  1  registered one-cycle pulse that accompanies pixel (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628).
- Counters:
  - h_count is 0..H_TOTAL-1 and increments every clock.
  - At H_TOTAL-1, h_count wraps to 0 and v_count increments.
  - v_count wraps to 0 at V_TOTAL-1, only when h_count also wraps.
  - Counter widths are $clog2 of the respective totals.
- Phase FSM, one per axis, with states ACTIVE, FRONT, SYNC, BACK, always visited in that order.
  - Horizontal transitions occur at h_count = H_ACTIVE-1, H_ACTIVE+H_FP-1, H_ACTIVE+H_FP+H_SYNC-1 and H_TOTAL-1.
  - Vertical transitions use the same boundaries in lines and advance only on the h_count wrap cycle.
- VideoReady = (h_phase == ACTIVE) && (v_phase == ACTIVE). There is no other gating.
- Output register, latency 1:
  - On each edge where VideoReady is high, Red/Green/Blue <= Video and DataEnable <= 1.
  - Otherwise Red/Green/Blue <= 0 and DataEnable <= 0.
  - HSync <= HSYNC_POL when h_phase == SYNC, else ~HSYNC_POL. VSync follows the same rule with v_phase and VSYNC_POL.
  - FrameStart <= (h_count == 0 && v_count == 0).
- Reset:
  - Counters go to 0 and both FSMs go to ACTIVE.
  - Red/Green/Blue go to 0; DataEnable and FrameStart go to 0.
  - HSync goes to ~HSYNC_POL and VSync to ~VSYNC_POL.
  - VideoReady is high on the first cycle after Reset deasserts, because position (0,0) is active.
- Reset asserted mid-frame: the next edge restores the reset state and the frame restarts at (0,0). Upstream is reset from the same Reset, so no resynchronisation is needed.
- Simultaneous h and v wrap at (H_TOTAL-1, V_TOTAL-1): both counters go to 0 on the same edge.
- Exactly H_ACTIVE*V_ACTIVE VideoReady cycles per frame (480000 by default).

Optional Feature:
- Macro: VIDEO_TIMING_BORDER_EN
- Defined: pixels at column 0, column H_ACTIVE-1, row 0 and row V_ACTIVE-1 are output as 24'hFFFFFF instead of Video. VideoReady is unchanged, so upstream still consumes these pixels and stays aligned.
- Undefined: Video passes through unmodified and there is no border logic.

Decomposition:
- Shared package video_pkg holds:
  - the phase encoding (ACTIVE=2'd0, FRONT=2'd1, SYNC=2'd2, BACK=2'd3);
  - the default SVGA timing constants;
  - the pixel width constant (24).
- One sub-module, video_axis_counter (parameters ACTIVE/FP/SYNC/BP), instantiated once per axis.
  - Inputs: Clock, Reset, Advance.
  - Outputs: count, phase, wrap.

Test Plan:
- Reset released -> VideoReady=1 on cycle 0. FrameStart=1 and DataEnable=1 one cycle later. HSync/VSync idle high-inactive (0 with POL=1).
- Drive Video=count-of-accepts for one line -> Red/Green/Blue show 800 consecutive values, delayed 1 cycle. DataEnable falls after exactly 800 cycles. HSync is high for cycles 840..967 of the line.
- Full frame -> 480000 VideoReady cycles. VSync is high for lines 601..604. Next FrameStart arrives exactly 663168 cycles after the previous one.
- Reset asserted at h=500, v=300 -> next cycle: counters 0, all outputs at reset values, VideoReady=1 the cycle after deassertion.
- HSYNC_POL=0, VSYNC_POL=0 -> sync levels inverted; idle level is 1.
- With VIDEO_TIMING_BORDER_EN and Video=24'h123456 -> outputs FFFFFF at (0,y), (799,y), (x,0), (x,599) and 123456 elsewhere. VideoReady count per frame is still 480000.
